da_lms_ctrl: RTL and testbench
==============================

DA_LMS_CTRL -- requirements
Module: da_lms_ctrl

Interface
REQ-001 SHALL have parameter MU_SHIFT, default 6, giving the step size mu = 2^-MU_SHIFT (legal range 0..18).
REQ-002 SHALL have parameter FILT_LAT, default 1, giving the DA filter output register latency in cycles (legal range 1..7).
REQ-003 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: new sample offered.
REQ-007 SHALL have port in_ready, output, 1 bit: controller can accept a sample.
REQ-008 SHALL have port x_in, input, 8 bits, signed: new input sample.
REQ-009 SHALL have port d_in, input, 10 bits, signed: desired response for that sample.
REQ-010 SHALL have port adapt_en, input, 1 bit: enables the weight update for that sample.
REQ-011 SHALL have ports x0..x3, output, 8 bits each, signed: tap delay line driven to the DA filter.
REQ-012 SHALL have ports w0..w3, output, 8 bits each, two's complement: weights driven to the DA filter (bit 7 is the negative-weight bit).
REQ-013 SHALL have port filt_y, input, 10 bits, signed: DA filter output.
REQ-014 SHALL have port out_valid, output, 1 bit: result available.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-016 SHALL have port y_out, output, 10 bits, signed: captured filter output.
REQ-017 SHALL have port e_out, output, 11 bits, signed: error d - y.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, FILT, UPD and OUT.
REQ-020 SHALL drive in_ready=1 only in IDLE.
REQ-021 SHALL accept a sample on edge T0 when in_valid and in_ready are both high.
REQ-022 SHALL, on accept, shift the taps (x3<=x2, x2<=x1, x1<=x0, x0<=x_in), latch d_in and adapt_en, and enter FILT.
REQ-023 SHALL stay in FILT until it samples filt_y on edge T0+FILT_LAT+1; a down-counter sets the number of wait cycles.
REQ-024 SHALL, on that edge, register y_out=filt_y and e_out=d-filt_y, computed at 11-bit width so no overflow is possible.
REQ-025 SHALL then go to UPD if the latched adapt_en=1, otherwise to OUT.
REQ-026 SHALL update one tap per cycle in UPD, tap k on edge T0+FILT_LAT+2+k for k=0..3, then enter OUT after tap 3.
REQ-027 SHALL compute each update as: prod = e*x_k at 19-bit signed width; delta = prod arithmetically shifted right by MU_SHIFT (floor); w_k <= saturate of w_k+delta to [-128, 127].
REQ-028 SHALL hold x0..x3 and w0..w3 constant from T0 through the filt_y sample edge, so the DA filter sees stable operands.
REQ-029 SHALL hold out_valid=1 in OUT, with y_out and e_out stable, until out_ready=1; on that edge it SHALL return to IDLE.
REQ-030 SHALL drop out_valid in the cycle after the handshake and SHALL NOT raise in_ready in the same cycle as out_valid.
REQ-031 SHALL give accept-to-out_valid latency of FILT_LAT+5 cycles with adaptation and FILT_LAT+1 cycles without, when out_ready is held high.
REQ-032 SHALL ignore in_valid outside IDLE; no sample is lost or duplicated.
REQ-033 SHALL leave y_out and e_out holding the last result in IDLE.

Reset
REQ-034 SHALL, on rst, force the FSM to IDLE.
REQ-035 SHALL, on rst, clear x0..x3, w0..w3, y_out, e_out, the counter and the latched adapt_en/d to 0.
REQ-036 SHALL, after rst, drive in_ready=1, out_valid=0 and busy=0.
REQ-037 SHALL give rst priority over every event, including a mid-FILT, mid-UPD or OUT-stall reset and a simultaneous accept; nothing partial is retained.

Verification
REQ-038 SHALL verify post-reset values: all taps, weights, y_out and e_out =0; in_ready=1; out_valid=0.
REQ-039 SHALL verify a basic update: from reset, x_in=10, d_in=100, adapt_en=1, filt_y model returns 0 -> e_out=100, w0=15 ((1000)>>>6), w1..w3=0, out_valid rises 6 cycles after accept (FILT_LAT=1).
REQ-040 SHALL verify negative floor: with e=-100 and x0=10 -> delta=-16, so w0 goes 15 -> -1.
REQ-041 SHALL verify saturation and adaptation disable: with w0=120, e=500, x0=127 -> w0 saturates to 127; repeating with adapt_en=0 -> weights unchanged and latency is 2 cycles.
REQ-042 SHALL verify backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, y_out and e_out stay stable, in_ready=0, and no extra sample is accepted.
REQ-043 SHALL verify reset during UPD after tap 1 -> next cycle all weights =0, state is IDLE and out_valid=0.

Source files
------------

// File: rtl/da_lms_ctrl.sv
// ============================================================================
// da_lms_ctrl : LMS adaptation controller around an external 4-tap DA filter.
// Rev 1.0
// ============================================================================
`default_nettype none

module da_lms_ctrl #(
  parameter int MU_SHIFT = 6,
  parameter int FILT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x_in,
  input  logic signed [9:0] d_in,
  input  logic              adapt_en,
  output logic signed [7:0] x0,
  output logic signed [7:0] x1,
  output logic signed [7:0] x2,
  output logic signed [7:0] x3,
  output logic signed [7:0] w0,
  output logic signed [7:0] w1,
  output logic signed [7:0] w2,
  output logic signed [7:0] w3,
  input  logic signed [9:0] filt_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [9:0] y_out,
  output logic signed [10:0] e_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILT = 2'd1,
    UPD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [2:0] C_LAT = 3'(FILT_LAT);

  state_t            r_state;
  state_t            w_next;
  logic signed [7:0] r_x [4];
  logic signed [7:0] r_w [4];
  logic signed [9:0] r_d;
  logic              r_adapt;
  logic [2:0]        r_cnt;
  logic [1:0]        r_tap;
  logic signed [9:0] r_y;
  logic signed [10:0] r_e;

  logic signed [10:0] w_e;
  logic signed [7:0]  w_xk;
  logic signed [7:0]  w_wk;
  logic signed [18:0] w_prod;
  logic signed [18:0] w_delta;
  logic signed [19:0] w_sum;
  logic signed [7:0]  w_wsat;

  // Error is formed one bit wider than either operand, so it cannot wrap.
  assign w_e     = $signed({r_d[9], r_d}) - $signed({filt_y[9], filt_y});
  assign w_xk    = r_x[r_tap];
  assign w_wk    = r_w[r_tap];
  assign w_prod  = $signed({{8{r_e[10]}}, r_e}) * $signed({{11{w_xk[7]}}, w_xk});
  assign w_delta = w_prod >>> MU_SHIFT;
  assign w_sum   = $signed({w_delta[18], w_delta}) + $signed({{12{w_wk[7]}}, w_wk});

  always_comb begin
    w_wsat = w_sum[7:0];
    if (w_sum > 20'sd127) begin
      w_wsat = 8'sd127;
    end else if (w_sum < -20'sd128) begin
      w_wsat = -8'sd128;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = FILT;
      end
      FILT: begin
        if (r_cnt == 3'd0) w_next = r_adapt ? UPD : OUT;
      end
      UPD: begin
        if (r_tap == 2'd3) w_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
      r_d     <= '0;
      r_adapt <= 1'b0;
      r_cnt   <= '0;
      r_tap   <= '0;
      r_y     <= '0;
      r_e     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x[3]  <= r_x[2];
            r_x[2]  <= r_x[1];
            r_x[1]  <= r_x[0];
            r_x[0]  <= x_in;
            r_d     <= d_in;
            r_adapt <= adapt_en;
            r_cnt   <= C_LAT;
            r_tap   <= 2'd0;
          end
        end
        FILT: begin
          if (r_cnt == 3'd0) begin
            r_y <= filt_y;
            r_e <= w_e;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        UPD: begin
          r_w[r_tap] <= w_wsat;
          r_tap      <= r_tap + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign x0    = r_x[0];
  assign x1    = r_x[1];
  assign x2    = r_x[2];
  assign x3    = r_x[3];
  assign w0    = r_w[0];
  assign w1    = r_w[1];
  assign w2    = r_w[2];
  assign w3    = r_w[3];
  assign y_out = r_y;
  assign e_out = r_e;

endmodule

`default_nettype wire

// File: tb/tb_da_lms_ctrl.sv
// ============================================================================
// tb_da_lms_ctrl : randomized + directed bench for da_lms_ctrl with a DA filter model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_da_lms_ctrl;

  localparam int MU_SHIFT = 6;
  localparam int FILT_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic adapt_en = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] x_in = '0;
  logic signed [9:0] d_in = '0;
  logic signed [9:0] filt_y;
  logic in_ready, out_valid, busy;
  logic signed [7:0] x0, x1, x2, x3, w0, w1, w2, w3;
  logic signed [9:0] y_out;
  logic signed [10:0] e_out;

  int n_chk = 0;
  int n_bad = 0;
  int mx[4];
  int mw[4];
  bit y_zero = 1'b1;
  logic signed [9:0] r_pipe [FILT_LAT];

  da_lms_ctrl #(.MU_SHIFT(MU_SHIFT), .FILT_LAT(FILT_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .d_in(d_in), .adapt_en(adapt_en),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .filt_y(filt_y), .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .e_out(e_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Environment DA filter: y = floor(sum x_k*w_k / 128), clipped to 10 bits.
  function automatic int da_y(input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3);
    return clamp(fdiv(a0*b0 + a1*b1 + a2*b2 + a3*b3, 128), -512, 511);
  endfunction

  always @(posedge clk) begin
    r_pipe[0] <= 10'(da_y(int'(x0), int'(x1), int'(x2), int'(x3),
                          int'(w0), int'(w1), int'(w2), int'(w3)));
    for (int i = 1; i < FILT_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign filt_y = y_zero ? 10'sd0 : r_pipe[FILT_LAT-1];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string pfx);
    int ax[4];
    int aw[4];
    ax[0] = int'(x0); ax[1] = int'(x1); ax[2] = int'(x2); ax[3] = int'(x3);
    aw[0] = int'(w0); aw[1] = int'(w1); aw[2] = int'(w2); aw[3] = int'(w3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_x%0d", pfx, k), ax[k], mx[k]);
      check($sformatf("%s_w%0d", pfx, k), aw[k], mw[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
  endtask

  task automatic run_txn(input int x, input int d, input bit ad, input int stall, input bit hold_valid);
    int n;
    int y_e;
    int e_e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before", int'(in_ready), 1);
    x_in = 8'(x);
    d_in = 10'(d);
    adapt_en = ad;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    y_e = y_zero ? 0 : da_y(mx[0], mx[1], mx[2], mx[3], mw[0], mw[1], mw[2], mw[3]);
    e_e = d - y_e;
    if (ad) begin
      for (int k = 0; k < 4; k++)
        mw[k] = clamp(mw[k] + fdiv(e_e * mx[k], 1 << MU_SHIFT), -128, 127);
    end
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, ad ? FILT_LAT + 5 : FILT_LAT + 1);
    check("y_out", int'(y_out), y_e);
    check("e_out", int'(e_out), e_e);
    check_regs("res");
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_y", int'(y_out), y_e);
      check("stall_e", int'(e_out), e_e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
    check("idle_y_hold", int'(y_out), y_e);
    check_regs("hs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
    do_reset();
    check_regs("reset");
    check("reset_y", int'(y_out), 0);
    check("reset_e", int'(e_out), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);

    y_zero = 1'b1;
    run_txn(10, 100, 1'b1, 0, 1'b0);
    check("basic_e", int'(e_out), 100);
    check("basic_w0", int'(w0), 15);
    check("basic_w1", int'(w1), 0);
    run_txn(10, -100, 1'b1, 0, 1'b0);
    check("floor_w0", int'(w0), -1);

    do_reset();
    run_txn(127, 60, 1'b1, 0, 1'b0);
    run_txn(64, 1, 1'b1, 0, 1'b0);
    check("pre_sat_w0", int'(w0), 120);
    run_txn(127, 500, 1'b1, 0, 1'b0);
    check("sat_w0", int'(w0), 127);
    run_txn(127, 500, 1'b0, 0, 1'b0);
    check("noadapt_w0", int'(w0), 127);

    run_txn(3, 50, 1'b1, 5, 1'b1);

    y_zero = 1'b0;
    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 1023)) - 512,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    y_zero = 1'b1;
    x_in = 8'sd100;
    d_in = 10'sd300;
    adapt_en = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (FILT_LAT + 3) @(posedge clk);
    #1;
    check("mid_upd_busy", int'(busy), 1);
    check("mid_upd_w0_nonzero", int'(w0 != 8'sd0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
    check_regs("upd_rst");
    check("upd_rst_out_valid", int'(out_valid), 0);
    check("upd_rst_busy", int'(busy), 0);
    check("upd_rst_in_ready", int'(in_ready), 1);

    rst = 1'b1;
    in_valid = 1'b1;
    x_in = 8'sd55;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_accept_x0", int'(x0), 0);
    check("rst_accept_busy", int'(busy), 0);

    run_txn(20, 40, 1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
